// File: rtl/mcp4921_spi_responder.sv
// MCP4921 DAC-side SPI responder: oversampled frame decoder, input/output DAC registers, 8-bit register port.
// Optional macro MCP4921_SHDN_MODEL_EN: dac_code forced to 0 while the latched nSHDN bit is 0.
module mcp4921_spi_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  SCK,
  input  logic                  nCS,
  input  logic                  SDI,
  input  logic                  nLDAC,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [11:0]           dac_code,
  output logic                  dac_gain1x,
  output logic                  dac_shdn,
  output logic                  frame_valid,
  output logic                  load_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ADDR_IN_LO  = DATA_WIDTH'(8'h30);
  localparam logic [DATA_WIDTH-1:0] ADDR_IN_HI  = DATA_WIDTH'(8'h31);
  localparam logic [DATA_WIDTH-1:0] ADDR_OUT_LO = DATA_WIDTH'(8'h32);
  localparam logic [DATA_WIDTH-1:0] ADDR_FCNT   = DATA_WIDTH'(8'h33);
  localparam logic [DATA_WIDTH-1:0] ADDR_ECNT   = DATA_WIDTH'(8'h34);
  localparam logic [DATA_WIDTH-1:0] ADDR_CTRL   = DATA_WIDTH'(8'h35);
  localparam logic [4:0]            BIT_MAX     = 5'd31;
  localparam logic [7:0]            CNT_MAX     = 8'hFF;

  // Pin order inside the synchronizer vector: {nLDAC, SDI, nCS, SCK}
  logic [SYNC_STAGES*4-1:0] sync_q, sync_d;
  logic [3:0]               prev_q, prev_d;
  logic [3:0]               last_s, rise_s, fall_s;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [14:0] in_q, in_d;     // {BUF, nGA, nSHDN, code[11:0]}
  logic [14:0] out_q, out_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        pend_q, pend_d;
  logic        frame_valid_q, frame_valid_d;
  logic        load_pulse_q, load_pulse_d;
  logic [11:0] dac_code_q, dac_code_d;
  logic        dac_gain_q, dac_gain_d;
  logic        dac_shdn_q, dac_shdn_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic ctrl_wr_s, clr_s, abort_s, good_s, accept_s, load_now_s;
  logic sck_rise_s, ncs_rise_s, ncs_fall_s, sdi_s, nldac_s, nldac_fall_s;
  logic unused_data_in_s;

  assign last_s       = sync_q[SYNC_STAGES*4-1 -: 4];
  assign rise_s       = last_s & ~prev_q;
  assign fall_s       = ~last_s & prev_q;
  assign sck_rise_s   = rise_s[0];
  assign ncs_rise_s   = rise_s[1];
  assign ncs_fall_s   = fall_s[1];
  assign sdi_s        = last_s[2];
  assign nldac_s      = last_s[3];
  assign nldac_fall_s = fall_s[3];
  assign unused_data_in_s = ^data_in[DATA_WIDTH-1:2];

  always_comb begin
    sync_d = {sync_q[(SYNC_STAGES-1)*4-1:0], nLDAC, SDI, nCS, SCK};
    prev_d = last_s;
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bitcnt_d      = bitcnt_q;
    in_d          = in_q;
    out_d         = out_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    pend_d        = 1'b0;
    frame_valid_d = 1'b0;
    load_pulse_d  = 1'b0;
    dac_code_d    = dac_code_q;
    dac_gain_d    = dac_gain_q;
    dac_shdn_d    = dac_shdn_q;
    data_out_d    = '0;

    ctrl_wr_s = we && (addr == ADDR_CTRL);
    clr_s     = ctrl_wr_s && data_in[0];
    abort_s   = ctrl_wr_s && data_in[1];
    good_s    = (bitcnt_q == 5'(FRAME_BITS)) && !shift_q[15];
    accept_s  = (state_q == CHECK) && good_s && !abort_s;

    case (state_q)
      IDLE: begin
        if (ncs_fall_s) begin
          bitcnt_d = 5'd0;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        if (sck_rise_s) begin
          shift_d = {shift_q[14:0], sdi_s};
          if (bitcnt_q != BIT_MAX) begin
            bitcnt_d = bitcnt_q + 5'd1;
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end else begin
          shift_d = shift_q;
        end
        // A repeated nCS falling edge is treated as a glitch and restarts the count
        if (ncs_fall_s) begin
          bitcnt_d = 5'd0;
        end else if (ncs_rise_s) begin
          state_d = CHECK;
        end else begin
          state_d = SHIFT;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (abort_s) begin
          in_d = in_q;
        end else if (good_s) begin
          in_d          = shift_q[14:0];
          frame_valid_d = 1'b1;
          frame_cnt_d   = (frame_cnt_q == CNT_MAX) ? CNT_MAX : frame_cnt_q + 8'd1;
          pend_d        = !nldac_s;
        end else begin
          err_cnt_d     = (err_cnt_q == CNT_MAX) ? CNT_MAX : err_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_s) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end

    if (clr_s) begin
      frame_cnt_d = 8'd0;
      err_cnt_d   = 8'd0;
    end else begin
      frame_cnt_d = frame_cnt_d;
    end

    // A fall coinciding with an accepted frame is folded into the deferred transfer
    load_now_s = pend_q || (nldac_fall_s && !accept_s);
    if (load_now_s) begin
      out_d        = in_q;
      load_pulse_d = 1'b1;
      dac_gain_d   = in_q[13];
      dac_shdn_d   = !in_q[12];
`ifdef MCP4921_SHDN_MODEL_EN
      dac_code_d   = in_q[12] ? in_q[11:0] : 12'h000;
`else
      dac_code_d   = in_q[11:0];
`endif
    end else begin
      out_d        = out_q;
    end

    case (addr)
      ADDR_IN_LO:  data_out_d = DATA_WIDTH'(in_q[7:0]);
      ADDR_IN_HI:  data_out_d = DATA_WIDTH'({in_q[14:12], 1'b0, in_q[11:8]});
      ADDR_OUT_LO: data_out_d = DATA_WIDTH'(out_q[7:0]);
      ADDR_FCNT:   data_out_d = DATA_WIDTH'(frame_cnt_q);
      ADDR_ECNT:   data_out_d = DATA_WIDTH'(err_cnt_q);
      default:     data_out_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q        <= '0;
      prev_q        <= 4'd0;
      state_q       <= IDLE;
      shift_q       <= 16'd0;
      bitcnt_q      <= 5'd0;
      in_q          <= 15'd0;
      out_q         <= 15'd0;
      frame_cnt_q   <= 8'd0;
      err_cnt_q     <= 8'd0;
      pend_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      load_pulse_q  <= 1'b0;
      dac_code_q    <= 12'd0;
      dac_gain_q    <= 1'b0;
      dac_shdn_q    <= 1'b0;
      data_out_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      bitcnt_q      <= bitcnt_d;
      in_q          <= in_d;
      out_q         <= out_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
      pend_q        <= pend_d;
      frame_valid_q <= frame_valid_d;
      load_pulse_q  <= load_pulse_d;
      dac_code_q    <= dac_code_d;
      dac_gain_q    <= dac_gain_d;
      dac_shdn_q    <= dac_shdn_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out    = data_out_q;
  assign dac_code    = dac_code_q;
  assign dac_gain1x  = dac_gain_q;
  assign dac_shdn    = dac_shdn_q;
  assign frame_valid = frame_valid_q;
  assign load_pulse  = load_pulse_q;

endmodule

// File: tb/tb_mcp4921_spi_responder.sv
// Directed self-checking bench for mcp4921_spi_responder: frame decode, load, errors, reset, saturation.
module tb_mcp4921_spi_responder;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       SCK = 1'b0;
  logic       nCS = 1'b1;
  logic       SDI = 1'b0;
  logic       nLDAC = 1'b1;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [11:0] dac_code;
  logic       dac_gain1x, dac_shdn, frame_valid, load_pulse;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fv_cnt = 0, lp_cnt = 0, fv_cyc = 0, lp_cyc = 0;
  logic [11:0] fv_code = 12'h000, lp_code = 12'h000;

  mcp4921_spi_responder dut (
    .clk(clk), .res(res), .SCK(SCK), .nCS(nCS), .SDI(SDI), .nLDAC(nLDAC),
    .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
    .dac_code(dac_code), .dac_gain1x(dac_gain1x), .dac_shdn(dac_shdn),
    .frame_valid(frame_valid), .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;

  // Pulse monitors sampled on the falling clock edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) begin
      fv_cnt  <= fv_cnt + 1;
      fv_cyc  <= cyc;
      fv_code <= dac_code;
    end
    if (load_pulse) begin
      lp_cnt  <= lp_cnt + 1;
      lp_cyc  <= cyc;
      lp_code <= dac_code;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      SDI = word[i];
      clk_wait(3);
      SCK = 1'b1;
      clk_wait(3);
      SCK = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int nbits);
    @(negedge clk);
    nCS = 1'b0;
    clk_wait(4);
    send_bits(word, nbits);
    clk_wait(3);
    nCS = 1'b1;
    clk_wait(8);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    clk_wait(2);
    d = data_out;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data_in = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic test_reset;
    logic [7:0] r;
    clk_wait(3);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out got=%h exp=00", data_out); end
    n_checks++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL rst_dac_code got=%h exp=000", dac_code); end
    n_checks++; if ({dac_gain1x, dac_shdn, frame_valid, load_pulse} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags got=%b exp=0000", {dac_gain1x, dac_shdn, frame_valid, load_pulse}); end
    res = 1'b0;
    clk_wait(6);
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL rst_frame_cnt got=%h exp=00", r); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL rst_err_cnt got=%h exp=00", r); end
  endtask

  // 0x3ABC: A/B=0 BUF=0 nGA=1 nSHDN=1 code=ABC -> reg31 = {0,1,1,0,A} = 0x6A
  task automatic test_good_frame;
    logic [7:0] r;
    int f0, l0;
    f0 = fv_cnt; l0 = lp_cnt;
    send_frame(32'h3ABC, 16);
    n_checks++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL gf_frame_valid got=%0d exp=%0d", fv_cnt - f0, 1); end
    n_checks++; if (lp_cnt !== l0) begin n_fail++; $display("FAIL gf_no_load got=%0d exp=0", lp_cnt - l0); end
    read_reg(8'h30, r);
    n_checks++; if (r !== 8'hBC) begin n_fail++; $display("FAIL gf_reg30 got=%h exp=BC", r); end
    read_reg(8'h31, r);
    n_checks++; if (r !== 8'h6A) begin n_fail++; $display("FAIL gf_reg31 got=%h exp=6A", r); end
    n_checks++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL gf_dac_code got=%h exp=000", dac_code); end
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL gf_frame_cnt got=%h exp=01", r); end
  endtask

  task automatic test_load;
    logic [7:0] r;
    int l0;
    l0 = lp_cnt;
    @(negedge clk);
    nLDAC = 1'b0;
    clk_wait(4);
    nLDAC = 1'b1;
    clk_wait(8);
    n_checks++; if (lp_cnt !== l0 + 1) begin n_fail++; $display("FAIL ld_pulses got=%0d exp=1", lp_cnt - l0); end
    n_checks++; if (dac_code !== 12'hABC) begin n_fail++; $display("FAIL ld_dac_code got=%h exp=ABC", dac_code); end
    n_checks++; if (dac_gain1x !== 1'b1) begin n_fail++; $display("FAIL ld_gain1x got=%b exp=1", dac_gain1x); end
    n_checks++; if (dac_shdn !== 1'b0) begin n_fail++; $display("FAIL ld_shdn got=%b exp=0", dac_shdn); end
    read_reg(8'h32, r);
    n_checks++; if (r !== 8'hBC) begin n_fail++; $display("FAIL ld_reg32 got=%h exp=BC", r); end
  endtask

  task automatic test_bad_frames;
    logic [7:0] r;
    int f0;
    f0 = fv_cnt;
    send_frame(32'h0000_1234, 15);
    send_frame(32'h0001_2345, 17);
    send_frame(32'h0000_B123, 16);
    n_checks++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL bad_no_valid got=%0d exp=0", fv_cnt - f0); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h03) begin n_fail++; $display("FAIL bad_err_cnt got=%h exp=03", r); end
    read_reg(8'h30, r);
    n_checks++; if (r !== 8'hBC) begin n_fail++; $display("FAIL bad_reg30 got=%h exp=BC", r); end
    read_reg(8'h31, r);
    n_checks++; if (r !== 8'h6A) begin n_fail++; $display("FAIL bad_reg31 got=%h exp=6A", r); end
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL bad_frame_cnt got=%h exp=01", r); end
  endtask

  // 0x1555: BUF=0 nGA=0 nSHDN=1 code=555
  task automatic test_ldac_held;
    int f0, l0;
    @(negedge clk);
    nLDAC = 1'b0;
    clk_wait(8);
    f0 = fv_cnt; l0 = lp_cnt;
    send_frame(32'h1555, 16);
    n_checks++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL held_valid got=%0d exp=1", fv_cnt - f0); end
    n_checks++; if (lp_cnt !== l0 + 1) begin n_fail++; $display("FAIL held_pulses got=%0d exp=1", lp_cnt - l0); end
    n_checks++; if (lp_cyc !== fv_cyc + 1) begin n_fail++; $display("FAIL held_latency got=%0d exp=1", lp_cyc - fv_cyc); end
    n_checks++; if (fv_code !== 12'hABC) begin n_fail++; $display("FAIL held_code_at_valid got=%h exp=ABC", fv_code); end
    n_checks++; if (lp_code !== 12'h555) begin n_fail++; $display("FAIL held_code_at_load got=%h exp=555", lp_code); end
    n_checks++; if ({dac_gain1x, dac_shdn} !== 2'b00) begin n_fail++; $display("FAIL held_flags got=%b exp=00", {dac_gain1x, dac_shdn}); end
    nLDAC = 1'b1;
    clk_wait(6);
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int f0;
    f0 = fv_cnt;
    @(negedge clk);
    nCS = 1'b0;
    clk_wait(4);
    send_bits(32'h0000_003A, 8);
    write_reg(8'h35, 8'h02);
    send_bits(32'h0000_00BC, 8);
    clk_wait(3);
    nCS = 1'b1;
    clk_wait(8);
    n_checks++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL abort_no_valid got=%0d exp=0", fv_cnt - f0); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h03) begin n_fail++; $display("FAIL abort_err_cnt got=%h exp=03", r); end
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h02) begin n_fail++; $display("FAIL abort_frame_cnt got=%h exp=02", r); end
    read_reg(8'h35, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL ctrl_reads_zero got=%h exp=00", r); end
  endtask

  // 0x3FFF: BUF=0 nGA=1 nSHDN=1 code=FFF -> reg31 = 0x6F
  task automatic test_reset_midframe;
    logic [7:0] r;
    @(negedge clk);
    nCS = 1'b0;
    clk_wait(4);
    send_bits(32'h0000_003F, 8);
    res = 1'b1;
    clk_wait(3);
    res = 1'b0;
    clk_wait(4);
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_rst_frame_cnt got=%h exp=00", r); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_rst_err_cnt got=%h exp=00", r); end
    n_checks++; if (dac_code !== 12'h000) begin n_fail++; $display("FAIL mid_rst_dac_code got=%h exp=000", dac_code); end
    nCS = 1'b1;
    clk_wait(8);
    send_frame(32'h3FFF, 16);
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL mid_frame_cnt got=%h exp=01", r); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL mid_err_cnt got=%h exp=00", r); end
    read_reg(8'h30, r);
    n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL mid_reg30 got=%h exp=FF", r); end
    read_reg(8'h31, r);
    n_checks++; if (r !== 8'h6F) begin n_fail++; $display("FAIL mid_reg31 got=%h exp=6F", r); end
  endtask

  task automatic test_saturation;
    logic [7:0] r;
    send_frame(32'h0000_1234, 15);
    for (int k = 0; k < 260; k++) send_frame(32'h3000, 16);
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'hFF) begin n_fail++; $display("FAIL sat_frame_cnt got=%h exp=FF", r); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h01) begin n_fail++; $display("FAIL sat_err_cnt got=%h exp=01", r); end
    write_reg(8'h35, 8'h01);
    read_reg(8'h33, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL clr_frame_cnt got=%h exp=00", r); end
    read_reg(8'h34, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL clr_err_cnt got=%h exp=00", r); end
    read_reg(8'h00, r);
    n_checks++; if (r !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got=%h exp=00", r); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_load;
    test_bad_frames;
    test_ldac_held;
    test_abort;
    test_reset_midframe;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
